// File: rtl/l2_lru_pkg.sv
// Shared types and geometry for the l2_cache_lru scheduler front end.
// Lock commands are queued as lock_cmd_t; the lock sequencer walks lock_state_t.
package l2_lru_pkg;

  localparam int NUM_SETS        = 256;
  localparam int NUM_WAYS        = 8;
  localparam int SET_INDEX_WIDTH = $clog2(NUM_SETS);
  localparam int WAY_INDEX_WIDTH = $clog2(NUM_WAYS);

  typedef struct packed {
    logic [SET_INDEX_WIDTH-1:0] set;
    logic [WAY_INDEX_WIDTH-1:0] way;
    logic                       value;
  } lock_cmd_t;

  typedef enum logic [1:0] {
    LOCK_IDLE,
    LOCK_RD,
    LOCK_WR
  } lock_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible without a pop.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg[AW-1:0]];
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/l2_cache_lru_sched.sv
// Arbitrates fills, tag-stage hits and queued lock commands onto the
// two-cycle read/update port of l2_cache_lru (fill > access > lock).
module l2_cache_lru_sched
  import l2_lru_pkg::*;
#(
  parameter int LOCK_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_req,
  input  logic [SET_INDEX_WIDTH-1:0] fill_req_set,
  output logic                       fill_way_valid,
  output logic [WAY_INDEX_WIDTH-1:0] fill_way_out,
  input  logic                       acc_req,
  input  logic [SET_INDEX_WIDTH-1:0] acc_req_set,
  input  logic                       acc_hit,
  input  logic [WAY_INDEX_WIDTH-1:0] acc_hit_way,
  output logic                       acc_stall,
  input  logic                       lock_cmd_valid,
  output logic                       lock_cmd_ready,
  input  logic [SET_INDEX_WIDTH-1:0] lock_cmd_set,
  input  logic [WAY_INDEX_WIDTH-1:0] lock_cmd_way,
  input  logic                       lock_cmd_value,
  output logic                       lock_done,
  output logic                       lru_fill_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_fill_set,
  output logic                       lru_access_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_access_set,
  output logic                       lru_access_update_en,
  output logic [WAY_INDEX_WIDTH-1:0] lru_access_update_way,
  output logic                       lru_lock_en,
  output logic                       lru_lock_value,
  input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX  = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] STARVE_TRIP = CW'(STARVE_LIMIT - 1);

  lock_state_t state_reg, state_next, lock_phase;
  lock_cmd_t   head_cmd, push_cmd;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic        lock_issue, lock_wr, acc_win, starve_wait;
  logic        fill_valid_reg, won_acc_reg, acc_req_reg, stall_reg;
  logic [CW-1:0] starve_cnt_reg;

  assign push_cmd  = '{set: lock_cmd_set, way: lock_cmd_way, value: lock_cmd_value};
  assign fifo_push = lock_cmd_valid & lock_cmd_ready;

  sync_fifo #(
    .WIDTH($bits(lock_cmd_t)),
    .DEPTH(LOCK_FIFO_DEPTH)
  ) u_lock_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(push_cmd),
    .pop      (fifo_pop),
    .head_data(head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The lock read is issued in the very cycle a free slot is seen, so
  // LOCK_RD is the combinational phase of IDLE rather than a stored state.
  always_comb begin
    state_next = state_reg;
    lock_issue = 1'b0;
    case (state_reg)
      LOCK_IDLE: begin
        if (reset && !fifo_empty && !fill_req && !acc_req) begin
          lock_issue = 1'b1;
          state_next = LOCK_WR;
        end
      end
      LOCK_WR: state_next = LOCK_IDLE;
      default: state_next = LOCK_IDLE;
    endcase
  end

  assign lock_phase  = lock_issue ? LOCK_RD : state_reg;
  assign lock_wr     = reset && (lock_phase == LOCK_WR);
  assign fifo_pop    = lock_wr;
  assign acc_win     = reset & acc_req & ~fill_req;
  assign starve_wait = reset && (state_reg == LOCK_IDLE) && !fifo_empty && !lock_issue;

  always_comb begin
    lru_fill_en           = reset & fill_req;
    lru_fill_set          = lru_fill_en ? fill_req_set : '0;
    lru_access_en         = acc_win | lock_issue;
    lru_access_set        = lock_issue ? head_cmd.set : (acc_win ? acc_req_set : '0);
    lru_access_update_en  = reset & acc_hit & won_acc_reg;
    lru_access_update_way = '0;
    if (lock_wr)                   lru_access_update_way = head_cmd.way;
    else if (lru_access_update_en) lru_access_update_way = acc_hit_way;
    lru_lock_en           = lock_wr;
    lru_lock_value        = lock_wr & head_cmd.value;
    lock_done             = lock_wr;
    lock_cmd_ready        = reset & ~fifo_full;
    fill_way_valid        = reset & fill_valid_reg;
    fill_way_out          = fill_way_valid ? lru_fill_way : '0;
    acc_stall             = reset & stall_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= LOCK_IDLE;
      fill_valid_reg <= 1'b0;
      won_acc_reg    <= 1'b0;
      acc_req_reg    <= 1'b0;
      stall_reg      <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      fill_valid_reg <= fill_req;
      won_acc_reg    <= acc_win;
      acc_req_reg    <= acc_req;
      if (lock_issue) begin
        starve_cnt_reg <= '0;
        stall_reg      <= 1'b0;
      end else if (starve_wait) begin
        if (starve_cnt_reg != STARVE_MAX) starve_cnt_reg <= starve_cnt_reg + 1'b1;
        if (starve_cnt_reg >= STARVE_TRIP) stall_reg <= 1'b1;
      end
    end
  end

  // A hit reported with no lookup the cycle before is a tag-stage protocol error.
  a_hit_needs_lookup: assert property (@(posedge clk) disable iff (!reset)
    acc_hit |-> acc_req_reg);

endmodule
